// File: rtl/mcp9808_i2c_target.sv
// MCP9808-compatible I2C target: oversamples SCL/SDA on clk, serves the sensor register map
// and pulls SDA low (open-drain) for ACK and read data. No clock stretching.
module mcp9808_i2c_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [3:0]  ADDR_FIXED  = 4'b0011,
   parameter logic [15:0] MANUF_ID    = 16'h0054,
   parameter logic [15:0] DEV_ID      = 16'h0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_pull,
   input  logic [2:0]  addr_pins,
   input  logic [15:0] t_amb,
   output logic [15:0] config_q,
   output logic [15:0] t_upper_q,
   output logic [15:0] t_lower_q,
   output logic [15:0] t_crit_q,
   output logic [1:0]  res_q,
   output logic        busy
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned REG_W  = 16;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_dly_q, sda_dly_q;
   logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   state_e                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [1:0]             byte_cnt_q, byte_cnt_d;
   logic [BYTE_W-1:0]      shift_q, shift_d, msb_q, msb_d;
   logic [3:0]             ptr_q, ptr_d;
   logic                   rw_q, rw_d, hi_q, hi_d;
   logic [REG_W-1:0]       snap_q, snap_d;
   logic                   pull_d, busy_d;
   logic [REG_W-1:0]       config_d, t_upper_d, t_lower_d, t_crit_d;
   logic [1:0]             res_d;

   logic [BYTE_W-1:0]      rx_byte, tx_byte;
   logic [REG_W-1:0]       rd_src, wval;
   logic                   tx_bit, last_bit;

   // Input synchronizers; idle bus level is high so reset can never fabricate an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
         sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_dly_q;
   assign scl_fall  = ~scl_s & scl_dly_q;
   assign start_det = ~sda_s & sda_dly_q & scl_s;
   assign stop_det  = sda_s & ~sda_dly_q & scl_s;

   assign rx_byte  = {shift_q[BYTE_W-2:0], sda_s};
   assign last_bit = (bit_cnt_q == 3'd7);
   assign wval     = {msb_q, shift_q};
   assign tx_byte  = hi_q ? snap_q[REG_W-1:BYTE_W] : snap_q[BYTE_W-1:0];
   assign tx_bit   = tx_byte[3'd7 - bit_cnt_q];

   // Register selected by the pointer, snapshotted when a read is addressed
   always_comb begin
      rd_src = '0;
      case (ptr_q)
         4'd1:    rd_src = config_q;
         4'd2:    rd_src = t_upper_q;
         4'd3:    rd_src = t_lower_q;
         4'd4:    rd_src = t_crit_q;
         4'd5:    rd_src = t_amb;
         4'd6:    rd_src = MANUF_ID;
         4'd7:    rd_src = DEV_ID;
         4'd8:    rd_src = {6'b0, res_q, 6'b0, res_q};
         default: rd_src = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      msb_d      = msb_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      hi_d       = hi_q;
      snap_d     = snap_q;
      pull_d     = sda_pull;
      busy_d     = busy;
      config_d   = config_q;
      t_upper_d  = t_upper_q;
      t_lower_d  = t_lower_q;
      t_crit_d   = t_crit_q;
      res_d      = res_q;

      if (stop_det) begin
         state_d = IDLE;
         pull_d  = 1'b0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         busy_d    = 1'b1;
      end else begin
         // SDA only changes while SCL is low, one cycle after the falling edge
         if (scl_fall) begin
            case (state_q)
               ADDR_ACK, PTR_ACK, WDATA_ACK: pull_d = 1'b1;
               RDATA:                        pull_d = ~tx_bit;
               default:                      pull_d = 1'b0;
            endcase
         end
         if (scl_rise) begin
            case (state_q)
               ADDR: begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     if (rx_byte[7:1] == {ADDR_FIXED, addr_pins}) begin
                        state_d = ADDR_ACK;
                        rw_d    = rx_byte[0];
                        snap_d  = rd_src;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  hi_d    = 1'b1;
                  state_d = rw_q ? RDATA : PTR;
               end
               PTR: begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     ptr_d   = rx_byte[3:0];
                     state_d = PTR_ACK;
                  end
               end
               PTR_ACK: begin
                  byte_cnt_d = '0;
                  state_d    = WDATA;
               end
               WDATA: begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) state_d = WDATA_ACK;
               end
               WDATA_ACK: begin
                  state_d = WDATA;
                  if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd0) begin
                     msb_d = shift_q;
                     if (ptr_q == 4'd8) res_d = shift_q[1:0];
                  end else if (byte_cnt_q == 2'd1) begin
                     case (ptr_q)
                        4'd1:    config_d  = wval & 16'h07FF;
                        4'd2:    t_upper_d = wval & 16'h1FFC;
                        4'd3:    t_lower_d = wval & 16'h1FFC;
                        4'd4:    t_crit_d  = wval & 16'h1FFC;
                        default: ;
                     endcase
                  end
               end
               RDATA: begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) state_d = RDATA_MACK;
               end
               RDATA_MACK: begin
                  if (sda_s) begin
                     state_d = IGNORE;
                  end else begin
                     hi_d    = ~hi_q;
                     state_d = RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         msb_q      <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         hi_q       <= 1'b1;
         snap_q     <= '0;
         sda_pull   <= 1'b0;
         busy       <= 1'b0;
         config_q   <= '0;
         t_upper_q  <= '0;
         t_lower_q  <= '0;
         t_crit_q   <= '0;
         res_q      <= 2'b11;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         msb_q      <= msb_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         hi_q       <= hi_d;
         snap_q     <= snap_d;
         sda_pull   <= pull_d;
         busy       <= busy_d;
         config_q   <= config_d;
         t_upper_q  <= t_upper_d;
         t_lower_q  <= t_lower_d;
         t_crit_q   <= t_crit_d;
         res_q      <= res_d;
      end
   end

endmodule
